// File: rtl/line_window_fetch_pkg.sv
// Shared types and constants for the line window fetcher.
package line_window_fetch_pkg;
  localparam int ROW_WORDS = 24;
  localparam int ADDR_W    = 7;
  localparam int PIX_W     = 8;
  localparam int WORD_W    = 4 * PIX_W;
  localparam int COL_W     = 5;
  localparam int NUM_BANKS = 3;
  localparam int MEM_DEPTH = NUM_BANKS * ROW_WORDS;

  typedef enum logic [2:0] {
    ST_PACK,
    ST_WRITE,
    ST_RD0,
    ST_RD1,
    ST_CAP,
    ST_OUT
  } state_e;

  // Next bank in the 3-entry ring.
  function automatic logic [1:0] bank_inc(input logic [1:0] b);
    return (b == 2'(NUM_BANKS - 1)) ? 2'd0 : b + 2'd1;
  endfunction

  // Row-store address of a bank/column pair; max 71, fits ADDR_W without wrapping.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [1:0] b, input logic [COL_W-1:0] c);
    return ADDR_W'(b) * ADDR_W'(ROW_WORDS) + ADDR_W'(c);
  endfunction
endpackage

// File: rtl/line_window_fetch_if.sv
// Pixel stream, row-store and window bus of the line window fetcher.
interface line_window_fetch_if;
  import line_window_fetch_pkg::*;

  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic [PIX_W-1:0]  pix_data;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wr_data;
  logic [WORD_W-1:0] mem_rd_data;
  logic              win_valid;
  logic              win_ready;
  logic [WORD_W-1:0] win_top;
  logic [WORD_W-1:0] win_mid;
  logic [WORD_W-1:0] win_bot;
  logic [COL_W-1:0]  win_col;
  logic              win_last;

  // Fetcher side.
  modport master (
    input  pix_valid, pix_sof, pix_data, mem_rd_data, win_ready,
    output pix_ready, mem_write_en, mem_addr, mem_wr_data,
           win_valid, win_top, win_mid, win_bot, win_col, win_last
  );

  // Environment side: pixel source, row store and window consumer.
  modport slave (
    output pix_valid, pix_sof, pix_data, mem_rd_data, win_ready,
    input  pix_ready, mem_write_en, mem_addr, mem_wr_data,
           win_valid, win_top, win_mid, win_bot, win_col, win_last
  );
endinterface

// File: rtl/line_window_fetch_packer.sv
// Packs four little-endian pixels into one word; sof restarts the word.
module pixel_word_packer
  import line_window_fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_accept,
  input  logic              i_sof,
  input  logic [PIX_W-1:0]  i_pix,
  output logic [WORD_W-1:0] o_word,
  output logic              o_done
);
  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [1:0]        w_slot;

  // sof drops any partial word: the pixel lands in slot 0.
  assign w_slot = i_sof ? 2'd0 : r_cnt;
  assign o_done = i_accept && (w_slot == 2'd3);
  assign o_word = r_word;

  // Slot counter and byte lanes; counter wraps to 0 after the 4th pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (i_accept) begin
      r_cnt                        <= w_slot + 2'd1;
      r_word[w_slot*PIX_W +: PIX_W] <= i_pix;
    end
  end
endmodule

// File: rtl/line_window_fetch.sv
// Row-buffer controller: packs pixels, stores words in a 3-bank ring and
// emits a top/mid/bot column once two earlier rows are present.
module line_window_fetch
  import line_window_fetch_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  line_window_fetch_if.master bus
);
  state_e            r_state, w_next;
  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_bank_wr;
  logic [1:0]        r_rows;
  logic [WORD_W-1:0] r_win_top, r_win_mid, r_win_bot;

  logic              w_accept, w_done, w_we, w_advance, w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [WORD_W-1:0] w_word;
  logic [1:0]        w_bank_top, w_bank_mid;

  assign w_accept   = bus.pix_valid && !rst && (r_state == ST_PACK);
  assign w_bank_top = bank_inc(r_bank_wr);
  assign w_bank_mid = bank_inc(w_bank_top);
  assign w_last     = (r_col == COL_W'(ROW_WORDS - 1));

  pixel_word_packer u_packer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_accept (w_accept),
    .i_sof    (bus.pix_sof),
    .i_pix    (bus.pix_data),
    .o_word   (w_word),
    .o_done   (w_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_PACK;
    else     r_state <= w_next;
  end

  // Next state, memory strobe/address and the advance-on-return-to-PACK pulse.
  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_addr    = '0;
    w_advance = 1'b0;
    case (r_state)
      ST_PACK:  if (w_done) w_next = ST_WRITE;
      ST_WRITE: begin
        w_we   = 1'b1;
        w_addr = bank_addr(r_bank_wr, r_col);
        if (r_rows == 2'd2) begin
          w_next = ST_RD0;
        end else begin
          w_next    = ST_PACK;
          w_advance = 1'b1;
        end
      end
      ST_RD0: begin
        w_addr = bank_addr(w_bank_top, r_col);
        w_next = ST_RD1;
      end
      ST_RD1: begin
        w_addr = bank_addr(w_bank_mid, r_col);
        w_next = ST_CAP;
      end
      ST_CAP:   w_next = ST_OUT;
      ST_OUT: begin
        if (bus.win_ready) begin
          w_next    = ST_PACK;
          w_advance = 1'b1;
        end
      end
      default:  w_next = ST_PACK;
    endcase
  end

  // Column / bank / filled-row counters; sof restarts the frame geometry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_bank_wr <= 2'd0;
      r_rows    <= 2'd0;
    end else if (w_accept && bus.pix_sof) begin
      r_col     <= '0;
      r_bank_wr <= 2'd0;
      r_rows    <= 2'd0;
    end else if (w_advance) begin
      if (w_last) begin
        r_col     <= '0;
        r_bank_wr <= bank_inc(r_bank_wr);
        if (r_rows != 2'd2) r_rows <= r_rows + 2'd1;
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Window words: bot from the packer, top/mid from the two row-store reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_top <= '0;
      r_win_mid <= '0;
      r_win_bot <= '0;
    end else begin
      if (r_state == ST_WRITE) r_win_bot <= w_word;
      if (r_state == ST_RD1)   r_win_top <= bus.mem_rd_data;
      if (r_state == ST_CAP)   r_win_mid <= bus.mem_rd_data;
    end
  end

  // Output drive; everything is forced low while rst is asserted.
  always_comb begin
    bus.pix_ready    = !rst && (r_state == ST_PACK);
    bus.mem_write_en = !rst && w_we;
    bus.mem_addr     = rst ? '0 : w_addr;
    bus.mem_wr_data  = (!rst && w_we) ? w_word : '0;
    bus.win_valid    = !rst && (r_state == ST_OUT);
    bus.win_top      = rst ? '0 : r_win_top;
    bus.win_mid      = rst ? '0 : r_win_mid;
    bus.win_bot      = rst ? '0 : r_win_bot;
    bus.win_col      = rst ? '0 : r_col;
    bus.win_last     = !rst && w_last;
  end
endmodule

// File: tb/tb_line_window_fetch.sv
// Bench for line_window_fetch: frame-level model with a cycle checker, plus
// directed literal checks that pin the model.
module tb_line_window_fetch;
  import line_window_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_window_fetch_if bus();
  line_window_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Row store model: synchronous write, registered read.
  logic [WORD_W-1:0] mem [MEM_DEPTH];
  always @(posedge clk) begin
    if (bus.mem_write_en && bus.mem_addr < MEM_DEPTH) mem[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= (bus.mem_addr < MEM_DEPTH) ? mem[bus.mem_addr] : '0;
  end

  // Window consumer: 0 random, 1 always ready, 2 never ready.
  int ready_mode = 1;
  initial begin
    bus.win_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.win_ready = ($urandom_range(0, 2) != 0);
        1:       bus.win_ready = 1'b1;
        default: bus.win_ready = 1'b0;
      endcase
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct { logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] data; bit win; } wr_t;
  typedef struct { logic [WORD_W-1:0] top, mid, bot; int col; } win_t;

  wr_t               wq[$];
  win_t              winq[$];
  logic [7:0]        pb[$];
  logic [WORD_W-1:0] fw[int];       // words of the current frame by linear index
  int                widx = 0;
  bit                we_now = 0;
  int                due = 0;
  bit                hold = 0;

  int                wr_cnt = 0, win_cnt = 0, last_cnt = 0;
  logic [ADDR_W-1:0] lw_addr = '0;
  logic [WORD_W-1:0] lw_data = '0;
  bit                cap_arm = 0;
  logic [WORD_W-1:0] cap_top, cap_mid, cap_bot;
  logic [ADDR_W-1:0] cap_waddr;
  int                cap_col;

  always @(negedge clk) begin
    wr_t e;
    win_t w;
    logic [WORD_W-1:0] wd;
    int n, c;
    if (rst) begin
      chk("rst_outputs_zero", 32'(|{bus.pix_ready, bus.mem_write_en, bus.mem_addr, bus.mem_wr_data,
          bus.win_valid, bus.win_top, bus.win_mid, bus.win_bot, bus.win_col, bus.win_last}), 32'd0);
      pb.delete(); fw.delete(); wq.delete(); winq.delete();
      widx = 0; we_now = 0; due = 0; hold = 0;
    end else begin
      // A window becomes visible four cycles after its bottom word is written.
      if (due > 0) begin
        due--;
        if (due == 0) hold = 1;
      end
      chk("mem_write_en", 32'(bus.mem_write_en), 32'(we_now));
      if (bus.mem_write_en && we_now && wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("wr_data", bus.mem_wr_data, e.data);
        wr_cnt++;
        lw_addr = bus.mem_addr;
        lw_data = bus.mem_wr_data;
        if (e.win) due = 4;
      end
      chk("win_valid", 32'(bus.win_valid), 32'(hold));
      chk("pix_ready", 32'(bus.pix_ready), 32'(!we_now && due == 0 && !hold));
      if (hold && bus.win_valid && winq.size() > 0) begin
        w = winq[0];
        chk("win_top", bus.win_top, w.top);
        chk("win_mid", bus.win_mid, w.mid);
        chk("win_bot", bus.win_bot, w.bot);
        chk("win_col", 32'(bus.win_col), 32'(w.col));
        chk("win_last", 32'(bus.win_last), 32'(w.col == ROW_WORDS - 1));
        if (bus.win_ready) begin
          void'(winq.pop_front());
          hold = 0;
          win_cnt++;
          if (w.col == ROW_WORDS - 1) last_cnt++;
          if (cap_arm) begin
            cap_arm = 0; cap_top = bus.win_top; cap_mid = bus.win_mid;
            cap_bot = bus.win_bot; cap_col = int'(bus.win_col); cap_waddr = lw_addr;
          end
        end
      end
      we_now = 0;
      if (bus.pix_valid && bus.pix_ready) begin
        if (bus.pix_sof) begin
          pb.delete(); fw.delete(); widx = 0;
        end
        pb.push_back(bus.pix_data);
        if (pb.size() == 4) begin
          wd = {pb[3], pb[2], pb[1], pb[0]};
          pb.delete();
          n = widx / ROW_WORDS;
          c = widx % ROW_WORDS;
          fw[widx] = wd;
          wq.push_back('{addr: ADDR_W'((n % 3) * ROW_WORDS + c), data: wd, win: (n >= 2)});
          if (n >= 2)
            winq.push_back('{top: fw[widx - 2*ROW_WORDS], mid: fw[widx - ROW_WORDS], bot: wd, col: c});
          widx++;
          we_now = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] d, input bit s);
    bit acc;
    int g;
    acc = 0; g = 0;
    bus.pix_valid = 1'b1; bus.pix_data = d; bus.pix_sof = s;
    while (!acc) begin
      @(negedge clk); acc = bus.pix_ready;
      @(posedge clk); #1;
      g++;
      if (!acc && g > 300) begin
        checks++; errors++;
        $display("FAIL push_timeout actual=no_ready expected=ready t=%0t", $time);
        $fatal(1, "pixel stream stalled");
      end
    end
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int g;
    g = 0;
    while (!bus.win_valid && g < 30) begin idle(1); g++; end
    chk(nm, 32'(bus.win_valid), 32'd1);
  endtask

  int w0, wc0;

  initial begin
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = '0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    idle(3);
    rst = 1'b0;

    // Single word.
    push(8'h11, 1); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
    idle(4);
    chk("pack_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("pack_addr", 32'(lw_addr), 32'd0);
    chk("pack_data", lw_data, 32'h44332211);
    chk("pack_no_win", 32'(win_cnt), 32'd0);

    // Three-row fill, value = linear pixel index mod 256.
    cap_arm = 1;
    for (int p = 0; p < 3*96; p++) push(8'(p), p == 0);
    idle(8);
    chk("fill_top", cap_top, 32'h03020100);
    chk("fill_mid", cap_mid, 32'h63626160);
    chk("fill_bot", cap_bot, 32'hC3C2C1C0);
    chk("fill_col", 32'(cap_col), 32'd0);
    chk("fill_waddr", 32'(cap_waddr), 32'd48);
    chk("fill_wins", 32'(win_cnt), 32'd24);
    chk("fill_last", 32'(last_cnt), 32'd1);

    // Fourth row wraps into bank 0.
    cap_arm = 1;
    for (int p = 3*96; p < 4*96; p++) push(8'(p), 0);
    idle(8);
    chk("wrap_top", cap_top, 32'h63626160);
    chk("wrap_mid", cap_mid, 32'hC3C2C1C0);
    chk("wrap_bot", cap_bot, 32'h23222120);
    chk("wrap_waddr", 32'(cap_waddr), 32'd0);
    chk("wrap_end_addr", 32'(lw_addr), 32'd23);
    chk("wrap_last", 32'(last_cnt), 32'd2);

    // Backpressure on the last column of the fifth row.
    for (int p = 4*96; p < 5*96 - 4; p++) push(8'(p), 0);
    idle(8);
    ready_mode = 2;
    idle(1);
    for (int p = 5*96 - 4; p < 5*96; p++) push(8'(p), 0);
    wait_valid("bp_wait_valid");
    wc0 = wr_cnt;
    idle(10);
    chk("bp_valid_held", 32'(bus.win_valid), 32'd1);
    chk("bp_last", 32'(bus.win_last), 32'd1);
    chk("bp_col", 32'(bus.win_col), 32'd23);
    chk("bp_no_write", 32'(wr_cnt), 32'(wc0));
    chk("bp_ready_low", 32'(bus.pix_ready), 32'd0);
    ready_mode = 1;
    idle(3);
    chk("bp_resume", 32'(bus.win_valid), 32'd0);
    chk("bp_last_cnt", 32'(last_cnt), 32'd3);

    // Reset mid-stream; stale rows must never be emitted afterwards.
    for (int p = 0; p < 6; p++) push(8'($urandom), 0);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 32'(bus.pix_ready), 32'd1);
    @(posedge clk); #1;
    w0 = win_cnt;
    for (int p = 0; p < 2*96; p++) push(8'($urandom), 0);
    idle(8);
    chk("rst_no_win", 32'(win_cnt), 32'(w0));
    chk("rst_row1_end_addr", 32'(lw_addr), 32'd47);

    // sof after 2.5 rows drops the partial word and restarts geometry.
    for (int p = 0; p < 2*96 + 48 + 2; p++) push(8'($urandom), p == 0);
    idle(8);
    push(8'hA0, 1); push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 0);
    idle(4);
    chk("sof_addr", 32'(lw_addr), 32'd0);
    chk("sof_data", lw_data, 32'hA3A2A1A0);
    w0 = win_cnt;
    for (int p = 4; p < 2*96; p++) push(8'($urandom), 0);
    idle(8);
    chk("sof_no_win", 32'(win_cnt), 32'(w0));
    for (int p = 0; p < 4; p++) push(8'($urandom), 0);
    idle(8);
    chk("sof_first_win", 32'(win_cnt), 32'(w0 + 1));

    // Randomised frames with gaps, random consumer and occasional early sof.
    ready_mode = 0;
    for (int f = 0; f < 2; f++) begin
      int rows;
      rows = $urandom_range(3, 4);
      for (int p = 0; p < rows*96; p++) begin
        push(8'($urandom), (p == 0) || ($urandom_range(0, 399) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    ready_mode = 1;
    idle(12);
    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_winq_empty", 32'(winq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
